clock_enable_gen: RTL

- Parametrised multi-channel successor to the fixed-rate stopwatch clock dividers.
- Runs in a single clock domain and generates NUM_CH independent one-cycle tick enables plus square-wave outputs from clk_in.
- Each channel has a run-time programmable divisor with glitch-free reload, a global run/pause, and a synchronous realign.
- Downstream counters, display mux and blink logic consume the ticks as clock enables instead of using derived clocks.

---
 rtl/clock_enable_gen.sv | 113 +++++++++++
 1 files changed

// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator: per-channel tick pulses and square waves
// with shadowed divisor reload. Define CLKDIV_DUTY_EN to add a programmable duty cycle.
module clock_enable_gen #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 27,
  parameter int DEF_DIV = 50000000
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sync_clr,
  input  logic [NUM_CH*CNT_W-1:0] div_in,
`ifdef CLKDIV_DUTY_EN
  input  logic [NUM_CH*CNT_W-1:0] duty_in,
`endif
  input  logic [NUM_CH-1:0]       div_load,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       sq,
  output logic [NUM_CH-1:0]       pending
);

  localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
`ifdef CLKDIV_DUTY_EN
  localparam logic [CNT_W-1:0] DEF_DUTY_W = CNT_W'(DEF_DIV / 2);
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] active_div, shadow_div, cnt;
    logic [CNT_W-1:0] active_div_next, shadow_div_next, cnt_next;
    logic [CNT_W-1:0] div_slice;
    logic             tick_r, sq_r, pending_r;
    logic             tick_next, sq_next, pending_next;
    logic             wrap, apply;
`ifdef CLKDIV_DUTY_EN
    logic [CNT_W-1:0] active_duty, shadow_duty;
    logic [CNT_W-1:0] active_duty_next, shadow_duty_next;
    logic [CNT_W-1:0] duty_slice;

    assign duty_slice = duty_in[i*CNT_W +: CNT_W];
`endif

    assign div_slice = div_in[i*CNT_W +: CNT_W];
    assign wrap      = (active_div != '0) && (cnt == active_div - ONE);

    // The shadow is only promoted on a wrap, a realign, or while the channel is
    // disabled, so cnt always stays below the divisor in use.
    always_comb begin
      cnt_next  = cnt;
      tick_next = 1'b0;
      sq_next   = sq_r;
      apply     = 1'b0;
      if (sync_clr) begin
        cnt_next = '0;
        sq_next  = 1'b0;
        apply    = pending_r;
      end else if (en) begin
        if (active_div == '0) begin
          cnt_next = '0;
          apply    = pending_r;
        end else if (wrap) begin
          cnt_next  = '0;
          tick_next = 1'b1;
          sq_next   = ~sq_r;
          apply     = pending_r;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      active_div_next = apply ? shadow_div : active_div;
      shadow_div_next = div_load[i] ? div_slice : shadow_div;
      pending_next    = div_load[i] | (pending_r & ~apply);
`ifdef CLKDIV_DUTY_EN
      active_duty_next = apply ? shadow_duty : active_duty;
      shadow_duty_next = div_load[i] ? duty_slice : shadow_duty;
      if (!sync_clr && en && (active_div != '0)) begin
        sq_next = (cnt_next < active_duty_next);
      end
`endif
    end

    always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
        active_div <= DEF_DIV_W;
        shadow_div <= DEF_DIV_W;
        cnt        <= '0;
        tick_r     <= 1'b0;
        sq_r       <= 1'b0;
        pending_r  <= 1'b0;
`ifdef CLKDIV_DUTY_EN
        active_duty <= DEF_DUTY_W;
        shadow_duty <= DEF_DUTY_W;
`endif
      end else begin
        active_div <= active_div_next;
        shadow_div <= shadow_div_next;
        cnt        <= cnt_next;
        tick_r     <= tick_next;
        sq_r       <= sq_next;
        pending_r  <= pending_next;
`ifdef CLKDIV_DUTY_EN
        active_duty <= active_duty_next;
        shadow_duty <= shadow_duty_next;
`endif
      end
    end

    assign tick[i]    = tick_r;
    assign sq[i]      = sq_r;
    assign pending[i] = pending_r;
  end

endmodule
